// File: rtl/uart_tx_control_module.sv
// 8N1 UART transmitter with a small input FIFO and an internal bit-period counter.
// Idle-high line, LSB first, one-cycle done pulse at the end of each stop bit.
module uart_tx_control_module #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_pin_out,
    output logic       tx_busy,
    output logic       tx_done_sig
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]        fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next_s;
    logic              ready_r;

    state_t            state_r;
    logic [BAUD_W-1:0] baud_r;
    logic [2:0]        bit_idx_r;
    logic [7:0]        shift_r;
    logic              pin_r;
    logic              busy_r;
    logic              done_r;

    logic              push_s;
    logic              pop_s;
    logic              baud_last_s;
    logic              fifo_empty_s;
    logic [7:0]        head_s;

    assign tx_ready    = ready_r;
    assign tx_pin_out  = pin_r;
    assign tx_busy     = busy_r;
    assign tx_done_sig = done_r;

    // Handshake, pop decision and next FIFO occupancy; pops only in IDLE or at the stop-bit end.
    always_comb begin
        baud_last_s  = (baud_r == BAUD_LAST);
        fifo_empty_s = (count_r == {CNT_W{1'b0}});
        head_s       = fifo_mem_r[rd_ptr_r];
        push_s       = tx_valid && ready_r;
        pop_s        = 1'b0;
        case (state_r)
            S_IDLE:  pop_s = !fifo_empty_s;
            S_STOP:  pop_s = baud_last_s && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage, pointers, occupancy and registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= tx_data;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != CNT_FULL);
        end
    end

    // Frame sequencer: start bit, eight data bits LSB first, stop bit, with back-to-back chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            pin_r     <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    pin_r  <= 1'b1;
                    busy_r <= 1'b0;
                    if (pop_s) begin
                        shift_r <= head_s;
                        baud_r  <= {BAUD_W{1'b0}};
                        pin_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last_s) begin
                        baud_r    <= {BAUD_W{1'b0}};
                        pin_r     <= shift_r[0];
                        bit_idx_r <= 3'd0;
                        state_r   <= S_DATA;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last_s) begin
                        baud_r  <= {BAUD_W{1'b0}};
                        shift_r <= {1'b0, shift_r[7:1]};
                        if (bit_idx_r != 3'd7) begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            pin_r     <= shift_r[1];
                        end else begin
                            pin_r   <= 1'b1;
                            state_r <= S_STOP;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_last_s) begin
                        baud_r <= {BAUD_W{1'b0}};
                        done_r <= 1'b1;
                        if (pop_s) begin
                            shift_r <= head_s;
                            pin_r   <= 1'b0;
                            state_r <= S_START;
                        end else begin
                            busy_r  <= 1'b0;
                            state_r <= S_IDLE;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    baud_r  <= {BAUD_W{1'b0}};
                    pin_r   <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_control_module.sv
// Randomized bench for uart_tx_control_module: a frame-level line model plus a few literal pins.
module tb_uart_tx_control_module;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_pin_out;
    logic       tx_busy;
    logic       tx_done_sig;

    uart_tx_control_module #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_pin_out(tx_pin_out), .tx_busy(tx_busy),
        .tx_done_sig(tx_done_sig)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: bytes waiting in the FIFO, and the frame on the line with its cycle position.
    logic [7:0] mq[$];
    logic       m_active = 1'b0;
    int         m_pos = 0;
    logic [9:0] m_frame = 10'h3FF;
    logic       m_done = 1'b0;
    logic       m_ready_pre;

    // Literal expectations: enable bits {ready, done, busy, pin}.
    logic [3:0] lit_en = 4'b0000;
    logic       lit_pin = 1'b1, lit_busy = 1'b0, lit_done = 1'b0, lit_ready = 1'b1;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_done   = 1'b0;
        end else begin
            m_ready_pre = (mq.size() != DEPTH);
            m_done = 1'b0;
            if (m_active) begin
                if (m_pos == 10*CPB - 1) begin
                    m_done = 1'b1;
                    if (mq.size() > 0) begin
                        m_frame = {1'b1, mq.pop_front(), 1'b0};
                        m_pos   = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_pos = m_pos + 1;
                end
            end else if (mq.size() > 0) begin
                m_frame  = {1'b1, mq.pop_front(), 1'b0};
                m_pos    = 0;
                m_active = 1'b1;
            end
            if (tx_valid && m_ready_pre) mq.push_back(tx_data);
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("pin",   tx_pin_out,  m_active ? m_frame[m_pos / CPB] : 1'b1);
        chk("busy",  tx_busy,     m_active);
        chk("done",  tx_done_sig, m_done);
        chk("ready", tx_ready,    (mq.size() != DEPTH));
        if (lit_en[0]) chk("lit_pin",   tx_pin_out,  lit_pin);
        if (lit_en[1]) chk("lit_busy",  tx_busy,     lit_busy);
        if (lit_en[2]) chk("lit_done",  tx_done_sig, lit_done);
        if (lit_en[3]) chk("lit_ready", tx_ready,    lit_ready);
    end

    // One clock edge with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [7:0] d);
        tx_valid = v;
        tx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lit(input logic [3:0] en, input logic p, input logic b,
                           input logic dn, input logic r);
        lit_en = en; lit_pin = p; lit_busy = b; lit_done = dn; lit_ready = r;
    endtask

    logic [9:0] a5_bits;
    int thr;

    initial begin
        a5_bits = 10'b1101001010;
        set_lit(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, 8'h00);

        // Single 0xA5 frame, every edge pinned to literal values.
        cyc(1'b1, 8'hA5);
        for (int e = 1; e <= 41; e++) begin
            cyc(1'b0, 8'h00);
            if (e <= 40) set_lit(4'b0111, a5_bits[(e-1)/CPB], 1'b1, 1'b0, 1'b1);
            else         set_lit(4'b0111, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        cyc(1'b0, 8'h00);
        set_lit(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (5) cyc(1'b0, 8'h00);

        // Back-to-back 0x00 then 0xFF.
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'hFF);
        repeat (90) cyc(1'b0, 8'h00);

        // FIFO full: six writes, the sixth sees ready low and is dropped.
        for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i));
        set_lit(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h06);
        set_lit(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (220) cyc(1'b0, 8'h00);

        // Push on the stop-bit terminal edge while one byte is queued.
        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h22);
        repeat (39) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h33);
        set_lit(4'b1111, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 8'h00);
        set_lit(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (130) cyc(1'b0, 8'h00);

        // Reset during data bit 3 of 0x3C with 0x55 queued.
        cyc(1'b1, 8'h3C);
        cyc(1'b1, 8'h55);
        repeat (17) cyc(1'b0, 8'h00);
        #1;
        rst_n = 1'b0;
        set_lit(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 8'h00);
        rst_n = 1'b1;
        set_lit(4'b0111, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (30) cyc(1'b0, 8'h00);
        set_lit(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h5A);
        repeat (45) cyc(1'b0, 8'h00);

        // Random traffic with varying write density.
        for (int blk = 0; blk < 12; blk++) begin
            case (blk % 3)
                0:       thr = 5;
                1:       thr = 30;
                default: thr = 90;
            endcase
            for (int i = 0; i < 200; i++) begin
                cyc($urandom_range(0, 99) < thr, 8'($urandom));
            end
        end
        repeat (500) cyc(1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
